sponge_absorb_buffer: RTL and testbench

Parametrised absorb front end for the Keccak sponge core. It accepts a header and message words over a valid/ready stream and packs them into rate-sized blocks for one of four selectable SHA-3/SHAKE modes. It applies the mode's domain suffix and pad10*1 padding in hardware, then presents completed blocks to the permute stage through a DEPTH-entry block queue with a valid/ack handshake. It is the next-generation load stage: it adds configurable width and depth, multi-rate operation and on-chip padding.

---
 rtl/sponge_absorb_buffer.sv | 178 +++++++++++++++++
 tb/tb_sponge_absorb_buffer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sponge_absorb_buffer.sv
// Absorb front end for the Keccak sponge: packs header-described messages into
// rate-sized blocks, applies domain suffix and pad10*1, and queues blocks for permute.
module sponge_absorb_buffer #(
  parameter  int W        = 64,
  parameter  int DEPTH    = 2,
  localparam int RATE_MAX = 1344
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [W-1:0]        data_in,
  output logic [RATE_MAX-1:0] block_o,
  output logic                block_valid_o,
  output logic                block_last_o,
  input  logic                block_ack_i,
  output logic [1:0]          mode_o,
  output logic [31:0]         output_size_o,
  output logic                ctrl_valid_o
);

  localparam int WB     = W / 8;
  localparam int NBYTES = RATE_MAX / 8;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {HDR0, HDR1, ABSORB, PAD, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [1:0]          mode_q;
  logic [31:0]         outSize_q;
  logic                ctrlValid_q;
  logic [23:0]         rem_q;
  logic [7:0]          off_q;
  logic [RATE_MAX-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]    last_q;
  logic [PTR_W-1:0]    head_q, tail_q;
  logic [CNT_W-1:0]    count_q;

  logic [RATE_MAX-1:0] fillBlk_d;
  logic [7:0]          rateB, suffix, take, sufPos, offWord;
  logic                full, pop, lastWord, blkFull, room;
  logic                dataWr, padWr, enq, enqLast;

  always_comb begin
    unique case (mode_q)
      2'd0:    rateB = 8'd168;
      2'd3:    rateB = 8'd72;
      default: rateB = 8'd136;
    endcase
  end

  assign suffix   = mode_q[1] ? 8'h06 : 8'h1F;
  assign full     = (count_q == CNT_W'(DEPTH));
  assign pop      = block_valid_o && block_ack_i;
  assign take     = (rem_q < 24'(WB)) ? rem_q[7:0] : 8'(WB);
  assign lastWord = (rem_q <= 24'(WB));
  assign blkFull  = ((off_q + 8'(WB)) == rateB);
  // A final word that exactly fills the block leaves no byte for the suffix.
  assign room     = !(blkFull && (rem_q == 24'(WB)));
  assign sufPos   = off_q + take;
  assign offWord  = off_q / 8'(WB);

  assign ready_o = !rst && ((state_q == HDR0) || (state_q == HDR1) ||
                            ((state_q == ABSORB) && !full));

  always_ff @(posedge clk) begin
    if (rst) state_q <= HDR0;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    dataWr  = 1'b0;
    padWr   = 1'b0;
    enq     = 1'b0;
    enqLast = 1'b0;
    unique case (state_q)
      HDR0: if (valid_i) state_d = HDR1;
      HDR1: if (valid_i) state_d = (rem_q == '0) ? PAD : ABSORB;
      ABSORB: begin
        if (valid_i && !full) begin
          dataWr = 1'b1;
          if (lastWord) begin
            enq = 1'b1;
            if (room) begin
              padWr   = 1'b1;
              enqLast = 1'b1;
              state_d = DRAIN;
            end else begin
              state_d = PAD;
            end
          end else if (blkFull) begin
            enq = 1'b1;
          end
        end
      end
      PAD: begin
        if (!full) begin
          padWr   = 1'b1;
          enq     = 1'b1;
          enqLast = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: if (pop && block_last_o) state_d = HDR0;
      default: state_d = HDR0;
    endcase
  end

  // Builds the next contents of the filling slot; slots are zeroed when popped.
  always_comb begin
    fillBlk_d = mem_q[tail_q];
    for (int b = 0; b < NBYTES; b++) begin
      if (dataWr && (8'(b / WB) == offWord) && (8'(b % WB) < take))
        fillBlk_d[b*8 +: 8] = data_in[(b % WB)*8 +: 8];
      if (padWr && (8'(b) == sufPos))
        fillBlk_d[b*8 +: 8] ^= suffix;
      if (padWr && (8'(b) == (rateB - 8'd1)))
        fillBlk_d[b*8 +: 8] ^= 8'h80;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= '0;
      outSize_q   <= '0;
      ctrlValid_q <= 1'b0;
      rem_q       <= '0;
      off_q       <= '0;
    end else begin
      ctrlValid_q <= (state_q == HDR1) && valid_i;
      if ((state_q == HDR0) && valid_i) begin
        mode_q <= data_in[1:0];
        rem_q  <= data_in[31:8];
      end
      if ((state_q == HDR1) && valid_i) outSize_q <= data_in[31:0];
      if (dataWr) rem_q <= rem_q - 24'(take);
      if (enq)         off_q <= '0;
      else if (dataWr) off_q <= off_q + 8'(WB);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      last_q <= '0;
    end else begin
      if (dataWr || padWr) mem_q[tail_q] <= fillBlk_d;
      if (enq) last_q[tail_q] <= enqLast;
      if (pop) mem_q[head_q] <= '0;
    end
  end

  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) tail_q <= ptrInc(tail_q);
      if (pop) head_q <= ptrInc(head_q);
      count_q <= count_q + CNT_W'(enq) - CNT_W'(pop);
    end
  end

  assign block_valid_o = (count_q != '0);
  assign block_o       = block_valid_o ? mem_q[head_q] : '0;
  assign block_last_o  = block_valid_o && last_q[head_q];
  assign mode_o        = mode_q;
  assign output_size_o = outSize_q;
  assign ctrl_valid_o  = ctrlValid_q;

endmodule

// File: tb/tb_sponge_absorb_buffer.sv
// Bench for sponge_absorb_buffer: a directed vector table, hand sequences for
// back-pressure and mid-message reset, and random messages against a pad10*1 model.
module tb_sponge_absorb_buffer;
  localparam int RMAX = 1344;

  logic clk = 1'b0;
  logic rst, valid, ack, use32;
  logic [63:0] data;
  always #5 clk = ~clk;

  logic ready64, ready32, bv64, bv32, bl64, bl32, cv64, cv32;
  logic [RMAX-1:0] blk64, blk32;
  logic [1:0] mode64, mode32;
  logic [31:0] os64, os32;

  sponge_absorb_buffer #(.W(64), .DEPTH(2)) dut64 (
    .clk(clk), .rst(rst), .valid_i(valid && !use32), .ready_o(ready64),
    .data_in(data), .block_o(blk64), .block_valid_o(bv64), .block_last_o(bl64),
    .block_ack_i(ack && !use32), .mode_o(mode64), .output_size_o(os64),
    .ctrl_valid_o(cv64));

  sponge_absorb_buffer #(.W(32), .DEPTH(2)) dut32 (
    .clk(clk), .rst(rst), .valid_i(valid && use32), .ready_o(ready32),
    .data_in(data[31:0]), .block_o(blk32), .block_valid_o(bv32), .block_last_o(bl32),
    .block_ack_i(ack && use32), .mode_o(mode32), .output_size_o(os32),
    .ctrl_valid_o(cv32));

  logic readyM, bvM, blM, cvM;
  logic [RMAX-1:0] blkM;
  logic [1:0] modeM;
  logic [31:0] osM;
  assign readyM = use32 ? ready32 : ready64;
  assign bvM    = use32 ? bv32 : bv64;
  assign blM    = use32 ? bl32 : bl64;
  assign cvM    = use32 ? cv32 : cv64;
  assign blkM   = use32 ? blk32 : blk64;
  assign modeM  = use32 ? mode32 : mode64;
  assign osM    = use32 ? os32 : os64;

  typedef struct {
    bit         w32;
    logic [1:0] mode;
    int         len;
    int         nBlk;
    int         pos0;
    logic [7:0] val0;
    int         pos1;
    logic [7:0] val1;
  } vec_t;

  int total = 0;
  int bad = 0;
  int seenCount;
  bit ackEn, gapMode;
  logic [7:0] msg [0:1023];
  logic [RMAX-1:0] expQ[$];
  bit expLastQ[$];
  logic [RMAX-1:0] lastSeen;

  function automatic int rateOf(input logic [1:0] m);
    return (m == 2'd0) ? 168 : (m == 2'd3) ? 72 : 136;
  endfunction

  function automatic logic [7:0] sufOf(input logic [1:0] m);
    return m[1] ? 8'h06 : 8'h1F;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic abortRun(input string why);
    total++;
    bad++;
    $display("[TB] FAIL %s actual=timeout required=progress", why);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic buildExpected(input logic [1:0] m, input int len);
    int r, nBlk;
    logic [7:0] pad [0:1023];
    logic [RMAX-1:0] blk;
    r = rateOf(m);
    nBlk = len / r + 1;
    for (int i = 0; i < nBlk * r; i++) pad[i] = (i < len) ? msg[i] : 8'h00;
    pad[len] ^= sufOf(m);
    pad[nBlk*r-1] ^= 8'h80;
    for (int b = 0; b < nBlk; b++) begin
      blk = '0;
      for (int i = 0; i < r; i++) blk[i*8 +: 8] = pad[b*r+i];
      expQ.push_back(blk);
      expLastQ.push_back(b == nBlk - 1);
    end
  endtask

  function automatic logic [63:0] wordOf(input int k, input int len, input int wb);
    logic [63:0] w;
    w = {8{8'hEE}};
    for (int j = 0; j < wb; j++)
      if (k*wb + j < len) w[j*8 +: 8] = msg[k*wb+j];
    return w;
  endfunction

  task automatic popCheck();
    logic [RMAX-1:0] exp;
    bit expLast;
    int idx;
    if (expQ.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL unexpectedBlock actual=valid required=no_block");
      return;
    end
    exp = expQ.pop_front();
    expLast = expLastQ.pop_front();
    lastSeen = blkM;
    seenCount++;
    total++;
    if (blkM !== exp) begin
      bad++;
      idx = 0;
      for (int i = 0; i < RMAX/8; i++)
        if (blkM[i*8 +: 8] !== exp[i*8 +: 8]) begin idx = i; break; end
      $display("[TB] FAIL blockData blk=%0d byte=%0d actual=%h required=%h",
               seenCount, idx, blkM[idx*8 +: 8], exp[idx*8 +: 8]);
    end
    checkOutput("blockLast", blM, expLast);
  endtask

  task automatic applyStimulus(input logic [63:0] w, input int gap);
    int n;
    n = 0;
    valid = 1'b0;
    repeat (gap) @(negedge clk);
    valid = 1'b1;
    data = w;
    while (!readyM && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!readyM) abortRun("wordAccept");
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic sendHeaders(input logic [1:0] m, input int len, input logic [31:0] osz, input bit gaps);
    logic [23:0] l24;
    l24 = len[23:0];
    applyStimulus({32'hDEADBEEF, l24, 6'h29, m}, gaps ? $urandom_range(0, 2) : 0);
    applyStimulus({32'hCAFEF00D, osz}, gaps ? $urandom_range(0, 2) : 0);
    checkOutput("ctrlPulse", cvM, 1);
    checkOutput("modeLatch", modeM, m);
    checkOutput("outSize", osM, osz);
    @(negedge clk);
    checkOutput("ctrlDrop", cvM, 0);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0) abortRun("drain");
    @(negedge clk);
    @(negedge clk);
    checkOutput("idleReady", readyM, 1);
    checkOutput("idleValid", bvM, 0);
  endtask

  task automatic runMessage(input bit w32, input logic [1:0] m, input int len,
                            input logic [31:0] osz, input bit gaps);
    int wb, nW;
    use32 = w32;
    gapMode = gaps;
    ackEn = 1'b1;
    expQ.delete();
    expLastQ.delete();
    seenCount = 0;
    wb = w32 ? 4 : 8;
    buildExpected(m, len);
    sendHeaders(m, len, osz, gaps);
    nW = (len + wb - 1) / wb;
    for (int k = 0; k < nW; k++) applyStimulus(wordOf(k, len, wb), gaps ? $urandom_range(0, 2) : 0);
    waitDrain();
  endtask

  // Consumer: acks visible blocks (randomly thinned in gap mode) and scores them.
  initial begin
    forever begin
      @(negedge clk);
      if (ackEn) begin
        ack = 1'b0;
        if (!rst && bvM && (!gapMode || $urandom_range(0, 2) != 0)) begin
          popCheck();
          ack = 1'b1;
        end
      end
    end
  end

  initial begin
    #900000;
    abortRun("watchdog");
  end

  initial begin
    vec_t vecs [11];
    vecs[0]  = '{1'b0, 2'd2, 0,   1, 0,   8'h06, 135, 8'h80};
    vecs[1]  = '{1'b0, 2'd0, 167, 1, 166, 8'hA6, 167, 8'h9F};
    vecs[2]  = '{1'b0, 2'd0, 168, 2, 0,   8'h1F, 167, 8'h80};
    vecs[3]  = '{1'b1, 2'd1, 135, 1, 134, 8'h86, 135, 8'h9F};
    vecs[4]  = '{1'b0, 2'd3, 71,  1, 70,  8'h46, 71,  8'h86};
    vecs[5]  = '{1'b1, 2'd1, 136, 2, 0,   8'h1F, 135, 8'h80};
    vecs[6]  = '{1'b1, 2'd2, 1,   1, 1,   8'h06, 135, 8'h80};
    vecs[7]  = '{1'b1, 2'd0, 0,   1, 0,   8'h1F, 167, 8'h80};
    vecs[8]  = '{1'b0, 2'd3, 144, 3, 0,   8'h06, 71,  8'h80};
    vecs[9]  = '{1'b0, 2'd2, 300, 3, 28,  8'h06, 135, 8'h80};
    vecs[10] = '{1'b1, 2'd3, 73,  2, 1,   8'h06, 71,  8'h80};

    rst = 1'b1; valid = 1'b0; ack = 1'b0; use32 = 1'b0; data = '0;
    ackEn = 1'b0; gapMode = 1'b0; seenCount = 0;
    for (int i = 0; i < 1024; i++) msg[i] = 8'(i);
    repeat (3) @(negedge clk);
    checkOutput("rstReady", readyM, 0);
    checkOutput("rstValid", bvM, 0);
    checkOutput("rstBlock", blkM != '0, 0);
    checkOutput("rstCtrl", cvM, 0);
    checkOutput("rstMode", modeM, 0);
    checkOutput("rstOutSize", osM, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("readyAfterRst", readyM, 1);

    for (int v = 0; v < 11; v++) begin
      runMessage(vecs[v].w32, vecs[v].mode, vecs[v].len, 32'(100 + v), 1'b0);
      checkOutput("vecBlocks", seenCount, vecs[v].nBlk);
      checkOutput("vecByteA", lastSeen[vecs[v].pos0*8 +: 8], vecs[v].val0);
      checkOutput("vecByteB", lastSeen[vecs[v].pos1*8 +: 8], vecs[v].val1);
    end

    // SHA3-512, 200 bytes, W=32: hold ack so both buffers fill, then release.
    use32 = 1'b1; ackEn = 1'b0; gapMode = 1'b0; ack = 1'b0;
    expQ.delete(); expLastQ.delete(); seenCount = 0;
    buildExpected(2'd3, 200);
    sendHeaders(2'd3, 200, 32'd64, 1'b0);
    for (int k = 0; k < 35; k++) applyStimulus(wordOf(k, 200, 4), 0);
    checkOutput("bpReadyBefore", readyM, 1);
    applyStimulus(wordOf(35, 200, 4), 0);
    checkOutput("bpReadyDrop", readyM, 0);
    repeat (3) @(negedge clk);
    checkOutput("bpReadyHeld", readyM, 0);
    checkOutput("bpValidHeld", bvM, 1);
    checkOutput("bpBlockStable", blkM == expQ[0], 1);
    popCheck();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checkOutput("bpReadyBack", readyM, 1);
    ackEn = 1'b1;
    for (int k = 36; k < 50; k++) applyStimulus(wordOf(k, 200, 4), 0);
    waitDrain();
    checkOutput("bpBlocks", seenCount, 3);
    checkOutput("bpSuffix", lastSeen[56*8 +: 8], 8'h06);
    checkOutput("bpPadEnd", lastSeen[71*8 +: 8], 8'h80);

    // Reset during the 10th word of a SHAKE256 message.
    use32 = 1'b0; ackEn = 1'b1;
    expQ.delete(); expLastQ.delete(); seenCount = 0;
    buildExpected(2'd1, 300);
    sendHeaders(2'd1, 300, 32'd32, 1'b0);
    for (int k = 0; k < 9; k++) applyStimulus(wordOf(k, 300, 8), 0);
    valid = 1'b1;
    data = wordOf(9, 300, 8);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midRstValid", bvM, 0);
    checkOutput("midRstReady", readyM, 0);
    checkOutput("midRstMode", modeM, 0);
    checkOutput("midRstOutSize", osM, 0);
    rst = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    checkOutput("midRstReadyAfter", readyM, 1);
    checkOutput("midRstEmpty", bvM, 0);
    runMessage(1'b0, 2'd2, 0, 32'd32, 1'b0);
    checkOutput("midRstOneBlock", seenCount, 1);

    for (int t = 0; t < 12; t++) begin
      bit w32;
      logic [1:0] m;
      int len;
      w32 = 1'($urandom_range(0, 1));
      m = 2'($urandom_range(0, 3));
      len = $urandom_range(0, 600);
      for (int i = 0; i < 1024; i++) msg[i] = 8'($urandom_range(0, 255));
      runMessage(w32, m, len, $urandom, 1'b1);
      checkOutput("rndBlocks", seenCount, len / rateOf(m) + 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
